// File: rtl/clk_period_meter_if.sv
// Bundles the measured input and the measurement results of clk_period_meter.
// The meter sits on the slave side; whoever drives sig_in and consumes results is master.
interface clk_period_meter_if #(
  parameter int CNT_W = 32
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  modport master (
    output sig_in,
    input  period, high_time, valid, locked, timeout
  );

  modport slave (
    input  sig_in,
    output period, high_time, valid, locked, timeout
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow, asynchronous sig_in in clock_in cycles.
// Define CLK_PERIOD_METER_AVG_EN to report period as the average of the last 4 raw periods.
module clk_period_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock_in,
  input  logic              reset,
  clk_period_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state;
  logic             sync_1, sync_2, sig_hist;
  logic             rise, fall, stall;
  logic [CNT_W-1:0] high_cnt, low_cnt, high_lat;
  logic [CNT_W-1:0] high_inc, low_inc, raw_period;
  logic [CNT_W:0]   raw_sum;

  assign rise = sync_2 & ~sig_hist;
  assign fall = ~sync_2 & sig_hist;

  // Counters saturate rather than wrap so an over-long level never reads short.
  assign high_inc   = (high_cnt == CNT_MAX) ? high_cnt : high_cnt + CNT_ONE;
  assign low_inc    = (low_cnt == CNT_MAX) ? low_cnt : low_cnt + CNT_ONE;
  assign raw_sum    = {1'b0, high_lat} + {1'b0, low_cnt};
  assign raw_period = raw_sum[CNT_W] ? CNT_MAX : raw_sum[CNT_W-1:0];

  // An edge arriving in the same cycle as the stall limit always takes priority.
  assign stall = ((state == MEAS_HIGH) && !fall && (high_cnt >= TIMEOUT_C)) ||
                 ((state == MEAS_LOW)  && !rise && (low_cnt  >= TIMEOUT_C));

`ifdef CLK_PERIOD_METER_AVG_EN
  logic [3:0][CNT_W-1:0] p_hist;
  logic [CNT_W+1:0]      p_sum, p_sum_next;
  logic [2:0]            p_cnt;

  assign p_sum_next = p_sum - {2'b00, p_hist[3]} + {2'b00, raw_period};
`endif

  // Both synchronizer stages and the history flop delay rise and fall equally,
  // so the measured intervals are unaffected by the synchronizer latency.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sig_hist <= 1'b0;
    end else begin
      sync_1   <= bus.sig_in;
      sync_2   <= sync_1;
      sig_hist <= sync_2;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      high_cnt      <= '0;
      low_cnt       <= '0;
      high_lat      <= '0;
      bus.period    <= '0;
      bus.high_time <= '0;
      bus.valid     <= 1'b0;
      bus.locked    <= 1'b0;
      bus.timeout   <= 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
      p_hist        <= '0;
      p_sum         <= '0;
      p_cnt         <= '0;
`endif
    end else begin
      bus.valid   <= 1'b0;
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            high_cnt <= CNT_ONE;
            state    <= MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            high_lat <= high_cnt;
            low_cnt  <= CNT_ONE;
            state    <= MEAS_LOW;
          end else begin
            high_cnt <= high_inc;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            high_cnt <= CNT_ONE;
            state    <= MEAS_HIGH;
`ifdef CLK_PERIOD_METER_AVG_EN
            p_hist <= {p_hist[2:0], raw_period};
            p_sum  <= p_sum_next;
            if (p_cnt != 3'd4) begin
              p_cnt <= p_cnt + 3'd1;
            end
            if (p_cnt >= 3'd3) begin
              bus.period    <= p_sum_next[CNT_W+1:2];
              bus.high_time <= high_lat;
              bus.valid     <= 1'b1;
              bus.locked    <= 1'b1;
            end
`else
            bus.period    <= raw_period;
            bus.high_time <= high_lat;
            bus.valid     <= 1'b1;
            bus.locked    <= 1'b1;
`endif
          end else begin
            low_cnt <= low_inc;
          end
        end
        default: state <= IDLE;
      endcase

      // Stall abandons the measurement but keeps the last reported results.
      if (stall) begin
        bus.timeout <= 1'b1;
        bus.locked  <= 1'b0;
        state       <= IDLE;
`ifdef CLK_PERIOD_METER_AVG_EN
        p_hist      <= '0;
        p_sum       <= '0;
        p_cnt       <= '0;
`endif
      end
    end
  end
endmodule
